key_param_ctrl: RTL and testbench
=================================

Name: key_param_ctrl

Overview:
- Consumer of the debounced key event interface: one-cycle `key_flag` strobe plus held active-high `key_value`.
- Decodes each key event into an edit of the Sobel edge threshold and display mode.
- Publishes the updated parameter set to the image pipeline through a valid/ready handshake.
- Buffers one pending event while a publish is outstanding.

Parameters:
- KEY_WIDTH, 4, width of `key_value`; keys 0..3 are decoded, higher bits are ignored.
- THRESH_DEFAULT, 8'd64, threshold value after reset and after the restore key.
- THRESH_STEP, 8'd4, increment/decrement applied per key event.
- THRESH_MIN, 8'd0, lower saturation bound.
- THRESH_MAX, 8'd250, upper saturation bound.
- MODE_NUM, 3, number of display modes; mode counts 0..MODE_NUM-1.
- LED_TIME, 24'd5_000_000, LED acknowledge pulse length in clk cycles.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- key_flag  input  1  one-cycle strobe: new key event
- key_value  input  KEY_WIDTH  active-high key code, valid when key_flag=1
- param_ready  input  1  pipeline accepts the parameter set
- param_valid  output  1  parameter set is stable and offered
- threshold  output  8  Sobel threshold
- mode  output  2  display mode
- drop_cnt  output  8  saturating count of discarded events
- led  output  KEY_WIDTH  acknowledge indication

Behaviour:
- Reset (rst=1 at a clk edge): threshold=THRESH_DEFAULT, mode=0, param_valid=0, drop_cnt=0, led=0, FSM=IDLE, pending buffer empty.
- Decode priority when several key_value bits are set: the lowest index wins.
  - bit0 = INC: threshold = min(threshold+THRESH_STEP, THRESH_MAX). Compute 9-bit, then clamp.
  - bit1 = DEC: threshold = max(threshold-THRESH_STEP, THRESH_MIN). Compute signed 9-bit, then clamp.
  - bit2 = RESTORE: threshold = THRESH_DEFAULT.
  - bit3 = MODE: mode = (mode==MODE_NUM-1) ? 0 : mode+1.
  - No bit set: NONE, no change, no publish.
- FSM states: IDLE, APPLY, OFFER.
  - IDLE: key_flag=1 → capture key_value, go to APPLY. A pending event also goes to APPLY and the buffer is cleared.
  - APPLY (1 cycle): update registers per decode.
    - If the code is NONE → IDLE.
    - Otherwise → OFFER; param_valid=1 on the next cycle.
  - Latency: key_flag at cycle N → new threshold/mode visible at N+2, param_valid=1 at N+2.
  - OFFER: hold threshold/mode/param_valid stable. When param_valid && param_ready at the edge → param_valid=0, go to IDLE.
    - Ready may arrive in the same cycle valid rises, giving a 1-cycle offer.
- Events arriving in APPLY or OFFER:
  - If the pending buffer is empty, the key code is stored there.
  - If the buffer is full, the event is dropped and drop_cnt increments, saturating at 255.
- Saturated edits still publish. Example: INC at THRESH_MAX publishes an unchanged value.
- key_flag coincident with the OFFER→IDLE transition goes to the pending buffer. It is serviced from IDLE on the next cycle.
- rst mid-OFFER: param_valid drops to 0 at that edge, pending event lost, all registers to reset values.

Optional Feature:
- Macro: KEY_LED_ACK_EN.
- Defined:
  - Entering APPLY with a non-NONE code sets led to the one-hot decoded key and loads a LED_TIME down-counter.
  - led clears when the counter reaches 0.
  - A new event restarts the counter and replaces the led pattern.
- Undefined: no counter is synthesized; led is tied to 0.

Test Plan:
- Reset, then INC (key_value=4'b0001), param_ready=1 → threshold=68 and param_valid=1 two cycles after key_flag; valid high for 1 cycle.
- 63 INC events from default → threshold saturates at 250. One DEC → 246. RESTORE (4'b0100) → 64.
- DEC ×17 from 64 → threshold reaches 0 and stays 0, with 17 publishes observed.
- MODE (4'b1000) ×4 → mode sequence 1,2,0,1. key_value=4'b1001 → treated as INC only; mode unchanged.
- param_ready=0, three INC events back-to-back:
  - First event offered with threshold=68; second event pending; drop_cnt=1.
  - Raise ready → 68 accepted, then 72 offered.
- Assert rst during OFFER → param_valid=0 next cycle, threshold=64, drop_cnt=0.
- With KEY_LED_ACK_EN and LED_TIME=10: INC → led=4'b0001 for 10 cycles, then 0.

Source files
------------

// File: rtl/key_param_if.sv
// key_param_if
//   Bundles the key-event input and the parameter-publish handshake of
//   key_param_ctrl.
//   master : controller side. It receives key events and param_ready and
//            drives param_valid, threshold and mode.
//   slave  : environment side (key debouncer plus image pipeline).
//   Signals:
//     key_flag     one-cycle strobe that marks a new key event
//     key_value    active-high key code, valid while key_flag=1
//     param_ready  the pipeline accepts the parameter set
//     param_valid  the parameter set is stable and offered
//     threshold    Sobel edge threshold
//     mode         display mode
interface key_param_if #(
    parameter int KEY_WIDTH = 4
) ();
    logic                 key_flag;
    logic [KEY_WIDTH-1:0] key_value;
    logic                 param_ready;
    logic                 param_valid;
    logic [7:0]           threshold;
    logic [1:0]           mode;

    modport master (
        input  key_flag, key_value, param_ready,
        output param_valid, threshold, mode
    );

    modport slave (
        output key_flag, key_value, param_ready,
        input  param_valid, threshold, mode
    );
endinterface

// File: rtl/key_param_ctrl.sv
// key_param_ctrl
//   Decodes debounced key events into edits of the Sobel threshold and the
//   display mode. It publishes each edited parameter set through a
//   valid/ready handshake and holds one event pending while a publish is
//   outstanding.
//   Ports:
//     clk      system clock
//     rst      synchronous, active-high reset
//     bus      key_param_if.master: key_flag/key_value in, param_ready in,
//              param_valid/threshold/mode out
//     drop_cnt saturating count of discarded events
//     led      acknowledge indication (one-hot of the last decoded key)
//   Optional feature: define KEY_LED_ACK_EN to enable the LED acknowledge
//   pulse. When it is undefined, led is tied to 0.
module key_param_ctrl #(
    parameter int          KEY_WIDTH      = 4,
    parameter logic [7:0]  THRESH_DEFAULT = 8'd64,
    parameter logic [7:0]  THRESH_STEP    = 8'd4,
    parameter logic [7:0]  THRESH_MIN     = 8'd0,
    parameter logic [7:0]  THRESH_MAX     = 8'd250,
    parameter int          MODE_NUM       = 3,
    parameter logic [23:0] LED_TIME       = 24'd5_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    key_param_if.master          bus,
    output logic [7:0]           drop_cnt,
    output logic [KEY_WIDTH-1:0] led
);

    typedef enum logic [1:0] {IDLE, APPLY, OFFER} state_t;
    typedef enum logic [2:0] {C_NONE, C_INC, C_DEC, C_RESTORE, C_MODE} code_t;

    state_t     state, state_d;
    logic [3:0] cur_key;     // event being applied (only keys 0..3 matter)
    logic [3:0] pend_key;
    logic       pend_vld;
    logic [7:0] thresh;
    logic [1:0] mode_q;
    code_t      code;

    logic cap_key, cap_pend, pend_st, pend_clr, drop, do_apply;

    // Lowest set bit wins.
    always_comb begin
        code = C_NONE;
        if      (cur_key[0]) code = C_INC;
        else if (cur_key[1]) code = C_DEC;
        else if (cur_key[2]) code = C_RESTORE;
        else if (cur_key[3]) code = C_MODE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d  = state;
        cap_key  = 1'b0;
        cap_pend = 1'b0;
        pend_st  = 1'b0;
        pend_clr = 1'b0;
        drop     = 1'b0;
        do_apply = 1'b0;
        case (state)
            IDLE: begin
                if (pend_vld) begin
                    // The buffered event goes first. A coincident new event
                    // takes over the slot that is being freed.
                    cap_pend = 1'b1;
                    state_d  = APPLY;
                    if (bus.key_flag) pend_st  = 1'b1;
                    else              pend_clr = 1'b1;
                end else if (bus.key_flag) begin
                    cap_key = 1'b1;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                do_apply = 1'b1;
                state_d  = (code == C_NONE) ? IDLE : OFFER;
            end
            OFFER: begin
                if (bus.param_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // While busy, including the OFFER->IDLE edge, an event is buffered
        // if the slot is free and dropped otherwise.
        if (state != IDLE && bus.key_flag) begin
            if (!pend_vld) pend_st = 1'b1;
            else           drop    = 1'b1;
        end
    end

    // Saturating threshold arithmetic.
    logic [8:0]        inc_sum;
    logic signed [9:0] dec_diff;
    logic [7:0]        thresh_inc, thresh_dec;

    always_comb begin
        inc_sum    = {1'b0, thresh} + {1'b0, THRESH_STEP};
        thresh_inc = (inc_sum > {1'b0, THRESH_MAX}) ? THRESH_MAX : inc_sum[7:0];
        dec_diff   = $signed({2'b00, thresh}) - $signed({2'b00, THRESH_STEP});
        thresh_dec = (dec_diff < $signed({2'b00, THRESH_MIN})) ? THRESH_MIN : dec_diff[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_key  <= '0;
            pend_key <= '0;
            pend_vld <= 1'b0;
            thresh   <= THRESH_DEFAULT;
            mode_q   <= '0;
            drop_cnt <= '0;
        end else begin
            if (cap_key)  cur_key <= bus.key_value[3:0];
            if (cap_pend) cur_key <= pend_key;
            if (pend_st) begin
                pend_key <= bus.key_value[3:0];
                pend_vld <= 1'b1;
            end else if (pend_clr) begin
                pend_vld <= 1'b0;
            end
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            if (do_apply) begin
                case (code)
                    C_INC:     thresh <= thresh_inc;
                    C_DEC:     thresh <= thresh_dec;
                    C_RESTORE: thresh <= THRESH_DEFAULT;
                    C_MODE:    mode_q <= (mode_q == 2'(MODE_NUM - 1)) ? 2'd0 : mode_q + 2'd1;
                    default:   ;
                endcase
            end
        end
    end

    // Valid is high exactly while in OFFER. Reset returns to IDLE, which
    // drops an outstanding offer at that edge.
    assign bus.param_valid = (state == OFFER);
    assign bus.threshold   = thresh;
    assign bus.mode        = mode_q;

`ifdef KEY_LED_ACK_EN
    logic [23:0]          led_cnt;
    logic [KEY_WIDTH-1:0] led_onehot;

    always_comb begin
        led_onehot = '0;
        case (code)
            C_INC:     led_onehot[0] = 1'b1;
            C_DEC:     led_onehot[1] = 1'b1;
            C_RESTORE: led_onehot[2] = 1'b1;
            C_MODE:    led_onehot[3] = 1'b1;
            default:   ;
        endcase
    end

    // Loading at the APPLY edge and clearing at the edge where the count
    // hits 0 keeps led lit for exactly LED_TIME cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_cnt <= '0;
            led     <= '0;
        end else if (do_apply && code != C_NONE) begin
            led_cnt <= LED_TIME;
            led     <= led_onehot;
        end else if (led_cnt != 24'd0) begin
            led_cnt <= led_cnt - 24'd1;
            if (led_cnt == 24'd1) led <= '0;
        end
    end
`else
    assign led = '0;
`endif

endmodule

// File: tb/tb_key_param_ctrl.sv
module tb_key_param_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] drop_cnt;
    logic [3:0] led;

    key_param_if #(.KEY_WIDTH(4)) bus ();

    key_param_ctrl #(.KEY_WIDTH(4), .LED_TIME(24'd10)) dut (
        .clk(clk), .rst(rst), .bus(bus), .drop_cnt(drop_cnt), .led(led)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int pub_cnt = 0;
    logic [9:0] exp_q[$];   // {mode, threshold}
    logic [7:0] m_th = 8'd64;
    logic [1:0] m_mode = 2'd0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: each accepted handshake pops and compares one expected set.
    always @(negedge clk) begin
        if (!rst && bus.param_valid && bus.param_ready) begin
            pub_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_publish: got th=%0d mode=%0d expected none",
                         bus.threshold, bus.mode);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({bus.mode, bus.threshold} != e) begin
                    n_bad++;
                    $display("FAIL publish: got th=%0d mode=%0d expected th=%0d mode=%0d",
                             bus.threshold, bus.mode, e[7:0], e[9:8]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bench model of one key event. It pushes the expected publish, if any.
    task automatic model(input logic [3:0] v);
        if (v[0])      m_th = (m_th > 8'd246) ? 8'd250 : m_th + 8'd4;
        else if (v[1]) m_th = (m_th < 8'd4) ? 8'd0 : m_th - 8'd4;
        else if (v[2]) m_th = 8'd64;
        else if (v[3]) m_mode = (m_mode == 2'd2) ? 2'd0 : m_mode + 2'd1;
        if (v != 4'b0000) exp_q.push_back({m_mode, m_th});
    endtask

    // Single event followed by enough cycles to return to IDLE (ready=1).
    task automatic send(input logic [3:0] v);
        model(v);
        bus.key_flag  = 1'b1;
        bus.key_value = v;
        tick();
        bus.key_flag  = 1'b0;
        bus.key_value = 4'b0000;
        repeat (3) tick();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int p0;
        bus.key_flag    = 1'b0;
        bus.key_value   = 4'b0000;
        bus.param_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_thresh", bus.threshold, 64);
        check("rst_mode", bus.mode, 0);
        check("rst_valid", bus.param_valid, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_led", led, 0);

        // First INC: the result is visible two edges after the strobe and
        // is offered for a single cycle.
        model(4'b0001);
        bus.key_flag = 1'b1; bus.key_value = 4'b0001;
        tick();
        bus.key_flag = 1'b0; bus.key_value = 4'b0000;
        check("lat_valid_n1", bus.param_valid, 0);
        tick();
        check("lat_valid_n2", bus.param_valid, 1);
        check("lat_thresh_n2", bus.threshold, 68);
        tick();
        check("valid_one_cycle", bus.param_valid, 0);
        tick();

        // Saturation at the top, then DEC and RESTORE.
        for (int i = 0; i < 63; i++) send(4'b0001);
        check("sat_max", bus.threshold, 250);
        send(4'b0010);
        check("dec_after_max", bus.threshold, 246);
        send(4'b0100);
        check("restore", bus.threshold, 64);

        // Saturation at the bottom. Saturated edits still publish.
        p0 = pub_cnt;
        for (int i = 0; i < 17; i++) send(4'b0010);
        check("sat_min", bus.threshold, 0);
        check("dec_publishes", pub_cnt - p0, 17);

        // Mode wrap and decode priority.
        send(4'b1000); check("mode_1", bus.mode, 1);
        send(4'b1000); check("mode_2", bus.mode, 2);
        send(4'b1000); check("mode_0", bus.mode, 0);
        send(4'b1000); check("mode_1b", bus.mode, 1);
        send(4'b1001);
        check("prio_mode", bus.mode, 1);
        check("prio_thresh", bus.threshold, 4);
        send(4'b0000);
        check("none_no_publish", exp_q.size(), 0);
        send(4'b0100);
        drain("drain_pre_bp");

        // Backpressure: three back-to-back INCs. One is applied, one is
        // pending and one is dropped.
        bus.param_ready = 1'b0;
        bus.key_flag = 1'b1; bus.key_value = 4'b0001;
        repeat (3) tick();
        bus.key_flag = 1'b0; bus.key_value = 4'b0000;
        model(4'b0001); model(4'b0001);
        check("bp_valid", bus.param_valid, 1);
        check("bp_thresh", bus.threshold, 68);
        check("bp_drop", drop_cnt, 1);
        repeat (3) tick();
        check("bp_hold_valid", bus.param_valid, 1);
        check("bp_hold_thresh", bus.threshold, 68);
        bus.param_ready = 1'b1;
        drain("bp_drain");
        repeat (2) tick();
        check("bp_final", bus.threshold, 72);

        // Reset while offering.
        bus.param_ready = 1'b0;
        bus.key_flag = 1'b1; bus.key_value = 4'b0001;
        tick();
        bus.key_flag = 1'b0; bus.key_value = 4'b0000;
        tick();
        check("pre_rst_valid", bus.param_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_th = 8'd64; m_mode = 2'd0;
        check("mid_rst_valid", bus.param_valid, 0);
        check("mid_rst_thresh", bus.threshold, 64);
        check("mid_rst_drop", drop_cnt, 0);
        bus.param_ready = 1'b1;
        repeat (3) tick();
        check("mid_rst_idle_valid", bus.param_valid, 0);

`ifdef KEY_LED_ACK_EN
        model(4'b0001);
        bus.key_flag = 1'b1; bus.key_value = 4'b0001;
        tick();
        bus.key_flag = 1'b0; bus.key_value = 4'b0000;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("led_on", led, 1);
            if (i < 9) tick();
        end
        tick();
        check("led_off", led, 0);
`else
        send(4'b0001);
        check("led_tied", led, 0);
`endif

        drain("final_queue");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
